// File: rtl/root_mult_unit_pkg.sv
// Shared definitions for the root/multiply function unit: FSM states, mode
// codes and the iteration-count / starting-shift helpers.
package root_mult_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ITER_CALC,
        ST_ITER_UPD,
        ST_MUL,
        ST_DONE
    } state_t;

    localparam logic MODE_SQRT = 1'b0;
    localparam logic MODE_CBRT = 1'b1;

    // Root digits produced: ceil(width/2) for sqrt, ceil(width/3) for cbrt.
    function automatic int iter_count(input int width, input logic mode);
        return (mode == MODE_CBRT) ? (width + 2) / 3 : (width + 1) / 2;
    endfunction

    function automatic int shift_start(input int width, input logic mode);
        return (iter_count(width, mode) - 1) * ((mode == MODE_CBRT) ? 3 : 2);
    endfunction

endpackage

// File: rtl/root_mult_unit_mult_seq.sv
// Shift-add sequential multiplier: one multiplier bit per cycle, busy_o high
// for exactly N cycles after the start edge, product valid once busy_o falls.
module mult_seq #(
    parameter int N = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [N-1:0]   a_bi,
    input  logic [N-1:0]   b_bi,
    output logic           busy_o,
    output logic [2*N-1:0] y_bo
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_N   = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [2*N-1:0] a_sh;
    logic [N-1:0]   b_sh;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            busy_o <= 1'b0;
            y_bo   <= '0;
        end else if (start_i && !busy_o) begin
            a_sh   <= {{N{1'b0}}, a_bi};
            b_sh   <= b_bi;
            cnt    <= CNT_N;
            busy_o <= 1'b1;
            y_bo   <= '0;
        end else if (busy_o) begin
            if (b_sh[0])
                y_bo <= y_bo + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CNT_ONE;
            if (cnt == CNT_ONE)
                busy_o <= 1'b0;
        end
    end

endmodule

// File: rtl/root_mult_unit.sv
// Integer square/cube root by digit-by-digit shift/compare, optionally scaled
// by a second operand through mult_seq; start/ready/done handshake.
//
// state        | meaning
// ST_IDLE      | ready, waiting for start_i
// ST_ITER_CALC | shift root left, form candidate increment
// ST_ITER_UPD  | compare remainder, accept digit, step shift
// ST_MUL       | wait for product (single pass-through cycle when MUL_EN=0)
// ST_DONE      | result on y_bo, done_o high, new start accepted
module root_mult_unit
    import root_mult_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [WIDTH-1:0]   x_bi,
    input  logic [WIDTH/2-1:0] b_bi,
    output logic [WIDTH-1:0]   y_bo,
    output logic               rdy_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int DW = 2 * WIDTH;
    localparam int N  = WIDTH / 2;

    localparam logic [7:0]       S0_SQRT = 8'(shift_start(WIDTH, MODE_SQRT));
    localparam logic [7:0]       S0_CBRT = 8'(shift_start(WIDTH, MODE_CBRT));
    localparam logic [DW-1:0]    ONE_D   = DW'(1);
    localparam logic [DW-1:0]    THREE_D = DW'(3);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [N-1:0]     ONE_N   = N'(1);

    state_t           state;
    logic [DW-1:0]    x_r;
    logic [DW-1:0]    c_r;
    logic [DW-1:0]    y_sh;
    logic [DW-1:0]    cand;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] mul_p;
    logic [WIDTH-1:0] result;
    logic [N-1:0]     b_r;
    logic [N-1:0]     root_fin;
    logic [7:0]       s_r;
    logic [7:0]       s_step;
    logic             mode_r;
    logic             ge;
    logic             mul_start;
    logic             mul_busy;

    assign y_sh   = {{WIDTH{1'b0}}, y_r[WIDTH-2:0], 1'b0};
    // Compare on the shifted-down remainder so c never needs to be shifted up.
    assign ge     = (x_r >> s_r) >= c_r;
    assign s_step = (mode_r == MODE_CBRT) ? 8'd3 : 8'd2;

    always_comb begin
        cand = (y_sh << 1) + ONE_D;
        if (mode_r == MODE_CBRT)
            cand = THREE_D * y_sh * (y_sh + ONE_D) + ONE_D;
    end

    // The multiplier is launched on the final update edge with the root as it
    // is being written, so its N busy cycles overlap the transition into MUL.
    assign root_fin  = ge ? y_r[N-1:0] + ONE_N : y_r[N-1:0];
    assign mul_start = (MUL_EN != 0) && (state == ST_ITER_UPD) && (s_r == 8'd0);
    assign result    = (MUL_EN != 0) ? mul_p : y_r;

    mult_seq #(
        .N (N)
    ) u_mult (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_bi    (root_fin),
        .b_bi    (b_r),
        .busy_o  (mul_busy),
        .y_bo    (mul_p)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ST_IDLE;
            x_r    <= '0;
            c_r    <= '0;
            y_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            mode_r <= MODE_SQRT;
            y_bo   <= '0;
            rdy_o  <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        x_r    <= {{WIDTH{1'b0}}, x_bi};
                        b_r    <= b_bi;
                        mode_r <= mode_i;
                        y_r    <= '0;
                        c_r    <= '0;
                        s_r    <= (mode_i == MODE_CBRT) ? S0_CBRT : S0_SQRT;
                        rdy_o  <= 1'b0;
                        busy_o <= 1'b1;
                        state  <= ST_ITER_CALC;
                    end else begin
                        rdy_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_ITER_CALC: begin
                    y_r   <= y_sh[WIDTH-1:0];
                    c_r   <= cand;
                    state <= ST_ITER_UPD;
                end
                ST_ITER_UPD: begin
                    if (ge) begin
                        x_r <= x_r - (c_r << s_r);
                        y_r <= y_r + ONE_W;
                    end
                    if (s_r == 8'd0) begin
                        state <= ST_MUL;
                    end else begin
                        s_r   <= s_r - s_step;
                        state <= ST_ITER_CALC;
                    end
                end
                ST_MUL: begin
                    if (!mul_busy) begin
                        y_bo   <= result;
                        done_o <= 1'b1;
                        rdy_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    rdy_o  <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_root_mult_unit.sv
// Bench for root_mult_unit: a multiplying and a root-only instance checked
// against a plain-arithmetic root/product/latency model.
module tb_root_mult_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        start1 = 1'b0;
    logic        mode1  = 1'b0;
    logic [31:0] x1     = '0;
    logic [15:0] b1     = '0;
    logic [31:0] y1;
    logic        rdy1, busy1, done1;

    logic        start0 = 1'b0;
    logic        mode0  = 1'b0;
    logic [31:0] x0     = '0;
    logic [15:0] b0     = '0;
    logic [31:0] y0;
    logic        rdy0, busy0, done0;

    int vectors     = 0;
    int miscompares = 0;

    localparam int NDIR = 7;
    bit          dir_m [NDIR] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] dir_x [NDIR] = '{32'd27, 32'd1000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd4291015624, 32'd0, 32'd0};
    logic [15:0] dir_b [NDIR] = '{16'd5, 16'd1, 16'd65535, 16'd1, 16'd1, 16'd777, 16'd4321};
    logic [31:0] dir_y [NDIR] = '{32'd15, 32'd1000, 32'd4294836225, 32'd1625,
                                  32'd1624, 32'd0, 32'd0};

    always #5 clk = ~clk;

    root_mult_unit #(.WIDTH(32), .MUL_EN(1)) dut_mul (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start1),
        .mode_i  (mode1),
        .x_bi    (x1),
        .b_bi    (b1),
        .y_bo    (y1),
        .rdy_o   (rdy1),
        .busy_o  (busy1),
        .done_o  (done1)
    );

    root_mult_unit #(.WIDTH(32), .MUL_EN(0)) dut_nomul (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start0),
        .mode_i  (mode0),
        .x_bi    (x0),
        .b_bi    (b0),
        .y_bo    (y0),
        .rdy_o   (rdy0),
        .busy_o  (busy0),
        .done_o  (done0)
    );

    // Largest r with r^2 <= x (or r^3 <= x), by bisection on plain integers.
    function automatic longint unsigned ref_root(input longint unsigned x, input bit cube);
        longint unsigned lo = 0;
        longint unsigned hi = cube ? 64'd2048 : 64'd65536;
        longint unsigned mid, p;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            p   = cube ? mid * mid * mid : mid * mid;
            if (p <= x) lo = mid;
            else        hi = mid;
        end
        return lo;
    endfunction

    function automatic int exp_lat(input bit cube, input bit mul);
        int k;
        k = cube ? (32 + 2) / 3 : 32 / 2;
        return 2 * k + (mul ? 16 : 0) + 1;
    endfunction

    task automatic wait_done(input bit sel0, input int lat_in,
                             output logic [31:0] yv, output int lat);
        lat = lat_in;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(sel0 ? done0 : done1) && lat < 200);
        yv = sel0 ? y0 : y1;
    endtask

    task automatic run_op(input bit sel0, input bit m, input logic [31:0] xv,
                          input logic [15:0] bv, output logic [31:0] yv, output int lat);
        @(negedge clk);
        if (sel0) begin
            mode0 = m; x0 = xv; b0 = bv; start0 = 1'b1;
        end else begin
            mode1 = m; x1 = xv; b1 = bv; start1 = 1'b1;
        end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        wait_done(sel0, 0, yv, lat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (y1 !== 32'd0)  begin miscompares++; $display("FAIL rst_y1: got %0d expected 0", y1); end
        vectors++; if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL rst_rdy1: got %b expected 1", rdy1); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL rst_busy1: got %b expected 0", busy1); end
        vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL rst_done1: got %b expected 0", done1); end
        vectors++; if (y0 !== 32'd0)  begin miscompares++; $display("FAIL rst_y0: got %0d expected 0", y0); end
        vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL rst_rdy0: got %b expected 1", rdy0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rst_busy0: got %b expected 0", busy0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL rst_done0: got %b expected 0", done0); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] yv;
        int lat;
        for (int i = 0; i < NDIR; i++) begin
            run_op(1'b0, dir_m[i], dir_x[i], dir_b[i], yv, lat);
            vectors++;
            if (yv !== dir_y[i]) begin
                miscompares++;
                $display("FAIL dir%0d_y: got %0d expected %0d", i, yv, dir_y[i]);
            end
            vectors++;
            if (lat != exp_lat(dir_m[i], 1'b1)) begin
                miscompares++;
                $display("FAIL dir%0d_lat: got %0d expected %0d", i, lat, exp_lat(dir_m[i], 1'b1));
            end
            if (i == 0) begin
                vectors++;
                if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL done_rdy: got %b expected 1", rdy1); end
                @(posedge clk);
                #1;
                vectors++;
                if (done1 !== 1'b0) begin miscompares++; $display("FAIL done_width: got %b expected 0", done1); end
                vectors++;
                if (y1 !== dir_y[0]) begin miscompares++; $display("FAIL y_hold: got %0d expected %0d", y1, dir_y[0]); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] yv, xv, expy;
        logic [15:0] bv;
        bit m;
        int lat;
        for (int i = 0; i < 16; i++) begin
            m  = 1'($urandom_range(0, 1));
            xv = $urandom;
            if (i % 4 == 0) xv = xv >> $urandom_range(0, 31);
            bv = 16'($urandom_range(0, 65535));
            run_op(1'b0, m, xv, bv, yv, lat);
            expy = 32'(ref_root({32'd0, xv}, m) * {48'd0, bv});
            vectors++;
            if (yv !== expy) begin
                miscompares++;
                $display("FAIL rnd%0d_y (m=%0d x=%0d b=%0d): got %0d expected %0d", i, m, xv, bv, yv, expy);
            end
            vectors++;
            if (lat != exp_lat(m, 1'b1)) begin
                miscompares++;
                $display("FAIL rnd%0d_lat: got %0d expected %0d", i, lat, exp_lat(m, 1'b1));
            end
        end
    endtask

    task automatic test_no_mul();
        logic [31:0] yv, xv, expy;
        bit m;
        int lat;
        for (int i = 0; i < 8; i++) begin
            m  = 1'($urandom_range(0, 1));
            xv = (i == 0) ? 32'd1000 : $urandom;
            if (i == 0) m = 1'b1;
            run_op(1'b1, m, xv, 16'($urandom_range(0, 65535)), yv, lat);
            expy = 32'(ref_root({32'd0, xv}, m));
            vectors++;
            if (yv !== expy) begin
                miscompares++;
                $display("FAIL nomul%0d_y (m=%0d x=%0d): got %0d expected %0d", i, m, xv, yv, expy);
            end
            vectors++;
            if (lat != exp_lat(m, 1'b0)) begin
                miscompares++;
                $display("FAIL nomul%0d_lat: got %0d expected %0d", i, lat, exp_lat(m, 1'b0));
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] yv;
        int lat;
        @(negedge clk);
        mode0 = 1'b1; x0 = 32'd1000; b0 = 16'd3; start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        lat = 0;
        repeat (5) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        mode0 = 1'b0; x0 = 32'd4000000; start0 = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        vectors++;
        if (busy0 !== 1'b1) begin miscompares++; $display("FAIL busy_hold: got %b expected 1", busy0); end
        start0 = 1'b0;
        x0 = 32'd64;
        wait_done(1'b1, lat, yv, lat);
        vectors++;
        if (yv !== 32'd10) begin miscompares++; $display("FAIL busy_ignore_y: got %0d expected 10", yv); end
        vectors++;
        if (lat != 23) begin miscompares++; $display("FAIL busy_ignore_lat: got %0d expected 23", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] yv;
        int lat;
        @(negedge clk);
        mode1 = 1'b1; x1 = 32'd125000; b1 = 16'd3; start1 = 1'b1;
        @(posedge clk);
        #1;
        mode1 = 1'b0; x1 = 32'd90000; b1 = 16'd7;
        wait_done(1'b0, 0, yv, lat);
        vectors++;
        if (yv !== 32'd150) begin miscompares++; $display("FAIL b2b_first_y: got %0d expected 150", yv); end
        vectors++;
        if (lat != 39) begin miscompares++; $display("FAIL b2b_first_lat: got %0d expected 39", lat); end
        @(posedge clk);
        #1;
        vectors++;
        if (busy1 !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy %b expected 1", busy1); end
        start1 = 1'b0;
        wait_done(1'b0, 0, yv, lat);
        vectors++;
        if (yv !== 32'd2100) begin miscompares++; $display("FAIL b2b_second_y: got %0d expected 2100", yv); end
        vectors++;
        if (lat != 49) begin miscompares++; $display("FAIL b2b_second_lat: got %0d expected 49", lat); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] yv;
        int lat, ndone;
        @(negedge clk);
        mode1 = 1'b0; x1 = $urandom | 32'h8000_0000; b1 = 16'd9; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (y1 !== 32'd0)   begin miscompares++; $display("FAIL abort_y: got %0d expected 0", y1); end
        vectors++; if (rdy1 !== 1'b1)  begin miscompares++; $display("FAIL abort_rdy: got %b expected 1", rdy1); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy1); end
        vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b expected 0", done1); end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done1) ndone++;
        end
        vectors++;
        if (ndone != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", ndone); end
        run_op(1'b0, 1'b1, 32'd970299, 16'd2, yv, lat);
        vectors++;
        if (yv !== 32'd198) begin miscompares++; $display("FAIL after_abort_y: got %0d expected 198", yv); end
        vectors++;
        if (lat != 39) begin miscompares++; $display("FAIL after_abort_lat: got %0d expected 39", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_no_mul();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
